// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// frame marker base and payload geometry.
package uart_tx_scheduler_pkg;

  localparam int unsigned PAYLOAD_W   = 56;
  localparam int unsigned ID_W        = 3;
  localparam logic [7:0]  MARKER_BASE = 8'hA0;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    GAP
  } state_e;

  // Marker byte is never zero, so the tx block always sends all 8 bytes.
  function automatic logic [7:0] marker(input logic [ID_W-1:0] id);
    return MARKER_BASE | {{(8-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins,
// reported as one-hot grant plus binary id.
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_SRC-1:0] grant_o,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  logic [ID_W-1:0]  cand;
  logic [N_SRC-1:0] req_sh;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    valid_o = 1'b0;
    cand    = '0;
    req_sh  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand   = ID_W'((32'(ptr_i) + k) % N_SRC);
      req_sh = req_i >> cand;
      if (!valid_o && req_sh[0]) begin
        valid_o = 1'b1;
        id_o    = cand;
        grant_o = N_SRC'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 64-bit-word UART transmitter among N_SRC producers: round-robin
// capture, one-cycle active-low launch, tx_done tracking and a watchdog.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned TIMEOUT_CYC = 70000,
  parameter int unsigned TO_W        = 17
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_SRC-1:0]           req,
  input  logic [N_SRC*PAYLOAD_W-1:0] payload,
  output logic [N_SRC-1:0]           ack,
  input  logic                       err_clr,
  output logic                       tx_en,
  output logic [63:0]                tx_byte,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id,
  output logic                       timeout_err
);

  state_e                 state_q;
  logic                   tx_en_q;
  logic [63:0]            tx_byte_q;
  logic [N_SRC-1:0]       ack_q;
  logic                   busy_q;
  logic [ID_W-1:0]        grant_id_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        rr_ptr_d;
  logic                   err_q;
  logic [TO_W-1:0]        cnt_q;

  logic [N_SRC-1:0]       win_grant;
  logic [ID_W-1:0]        win_id;
  logic                   win_valid;
  logic [PAYLOAD_W-1:0]   win_payload;
  logic                   wd_hit;

  rr_arbiter #(
    .N_SRC(N_SRC)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .grant_o(win_grant),
    .id_o   (win_id),
    .valid_o(win_valid)
  );

  always_comb begin
    win_payload = PAYLOAD_W'(payload >> (PAYLOAD_W * 32'(win_id)));
    rr_ptr_d    = (32'(win_id) == N_SRC - 1) ? '0 : win_id + ID_W'(1);
    wd_hit      = (cnt_q == TO_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_en_q    <= 1'b1;
      tx_byte_q  <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ack_q   <= '0;
      tx_en_q <= 1'b1;
      // A timeout in the same cycle as err_clr overrides the clear below.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            tx_byte_q  <= {marker(win_id), win_payload};
            grant_id_q <= win_id;
            ack_q      <= win_grant;
            busy_q     <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT_HI;
        end
        WAIT_HI, WAIT_LO: begin
          cnt_q <= cnt_q + TO_W'(1);
          if (wd_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (state_q == WAIT_HI && tx_done) begin
            state_q <= WAIT_LO;
          end else if (state_q == WAIT_LO && !tx_done) begin
            state_q <= GAP;
          end
        end
        GAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_byte     = tx_byte_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART tx block
// (4 clocks per bit), serial decoder and expected-frame scoreboard.
module tb_uart_tx_scheduler;

  localparam int unsigned N      = 4;
  localparam int unsigned TO_CYC = 1000;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req     = '0;
  logic [N*56-1:0] payload = '0;
  logic [N-1:0]    ack;
  logic            err_clr = 1'b0;
  logic            tx_en;
  logic [63:0]     tx_byte;
  logic            tx_done = 1'b0;
  logic            busy;
  logic [2:0]      grant_id;
  logic            timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int pend [N];
  int          ack_q [$];
  logic [63:0] frm_q [$];
  logic [63:0] dec_q [$];
  logic        stall = 1'b0;

  uart_tx_scheduler #(
    .N_SRC      (N),
    .TIMEOUT_CYC(TO_CYC),
    .TO_W       (10)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .payload    (payload),
    .ack        (ack),
    .err_clr    (err_clr),
    .tx_en      (tx_en),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frame(input int id);
    return {8'hA0 | 8'(id), payload[56*id +: 56]};
  endfunction

  // ---------------- behavioural UART tx block ----------------
  logic        m_act = 1'b0;
  logic [63:0] m_sh  = '0;
  logic [3:0]  m_bit = '0;
  logic [1:0]  m_clk = '0;
  logic        txd;

  assign txd = !m_act ? 1'b1 : (m_bit == 4'd0) ? 1'b0 : (m_bit == 4'd9) ? 1'b1 : m_sh[4'(m_bit - 4'd1)];

  always @(posedge clock) begin
    if (!m_act) begin
      if (tx_en === 1'b0 && !stall) begin
        m_act <= 1'b1; m_sh <= tx_byte; m_bit <= '0; m_clk <= '0;
      end
    end else if (m_clk == 2'd3) begin
      m_clk <= '0;
      if (m_bit == 4'd9) begin
        m_bit   <= '0;
        m_sh    <= m_sh >> 8;
        tx_done <= 1'b1;
        if ((m_sh >> 8) == 64'd0) begin
          m_act   <= 1'b0;
          tx_done <= 1'b0;
        end
      end else begin
        m_bit <= m_bit + 4'd1;
      end
    end else begin
      m_clk <= m_clk + 2'd1;
    end
  end

  // ---------------- monitors ----------------
  int          mon_id;
  logic [N-1:0] mon_ack;
  logic [63:0] mon_f;

  always @(negedge clock) begin
    if (ack !== '0) begin
      if (ack_q.size() == 0) check("ack_unexpected", 64'(ack_q.size()), 64'd1);
      else begin
        mon_id  = ack_q.pop_front();
        mon_ack = '0;
        mon_ack[mon_id] = 1'b1;
        check("ack_src", 64'(ack), 64'(mon_ack));
      end
    end
    if (tx_en === 1'b0) begin
      check("tx_en_while_tx_busy", 64'(m_act), 64'd0);
      if (frm_q.size() == 0) check("launch_unexpected", 64'(frm_q.size()), 64'd1);
      else begin
        mon_f = frm_q.pop_front();
        check("frame_word", tx_byte, mon_f);
        check("grant_id", 64'(grant_id), 64'(mon_f[58:56]));
        if (!stall) dec_q.push_back(mon_f);
      end
    end
  end

  logic       d_act = 1'b0;
  int         d_cnt = 0;
  int         d_idx = 0;
  logic [7:0] d_byte = '0;
  logic [63:0] d_exp;

  always @(negedge clock) begin
    if (!d_act) begin
      if (txd == 1'b0) begin d_act = 1'b1; d_cnt = 0; end
    end else begin
      d_cnt++;
      if (d_cnt >= 6 && d_cnt <= 34 && (d_cnt % 4) == 2) d_byte[(d_cnt - 6) / 4] = txd;
      if (d_cnt == 38) begin
        d_act = 1'b0;
        check("stop_bit", 64'(txd), 64'd1);
        if (dec_q.size() == 0) check("serial_unexpected", 64'(dec_q.size()), 64'd1);
        else begin
          d_exp = dec_q[0];
          check("serial_byte", 64'(d_byte), 64'(d_exp[8*d_idx +: 8]));
          d_idx++;
          if (d_idx == 8) begin
            d_idx = 0;
            void'(dec_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (ack[i] && pend[i] > 0) pend[i]--;
      req[i] = (pend[i] != 0);
    end
  endtask

  task automatic push(input int id);
    ack_q.push_back(id);
    frm_q.push_back(frame(id));
    pend[id]++;
    req[id] = 1'b1;
  endtask

  task automatic new_payloads();
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      r = {$urandom(), $urandom()};
      payload[56*i +: 56] = r[55:0];
    end
  endtask

  task automatic wait_done(input logic lvl, input string tag);
    int k = 0;
    while (tx_done !== lvl && k < 2000) begin step(); k++; end
    check(tag, 64'(tx_done), 64'(lvl));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    step();
    while (!(busy == 1'b0 && req == '0 && !m_act && frm_q.size() == 0) && k < 4000) begin
      step(); k++;
    end
    check({tag, "_idle"}, 64'(k < 4000), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    for (int i = 0; i < N; i++) pend[i] = 0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_tx_en",    64'(tx_en), 64'd1);
    check("rst_tx_byte",  tx_byte, 64'd0);
    check("rst_ack",      64'(ack), 64'd0);
    check("rst_busy",     64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_err",      64'(timeout_err), 64'd0);
    reset_n = 1'b1;
    step();

    // single source, all-zero payload
    push(0);
    step();
    check("t1_ack",  64'(ack), 64'h1);
    check("t1_busy", 64'(busy), 64'd1);
    step();
    check("t1_tx_en_lo", 64'(tx_en), 64'd0);
    check("t1_frame",    tx_byte, 64'hA000_0000_0000_0000);
    check("t1_ack_off",  64'(ack), 64'd0);
    step();
    check("t1_tx_en_hi", 64'(tx_en), 64'd1);
    wait_done(1'b1, "t1_done_rise");
    wait_done(1'b0, "t1_done_fall");
    check("t1_busy_at_fall", 64'(busy), 64'd1);
    step(); step();
    check("t1_busy_end", 64'(busy), 64'd0);

    // move rr_ptr to 2, then req 0 and 1 together: 0 first, then 1
    new_payloads();
    push(1);
    wait_idle("prep_ptr2");
    push(0); push(1);
    wait_idle("t3");

    // stalled transmitter: timeout on source 2, source 3 then served normally
    stall = 1'b1;
    push(2); push(3);
    k = 0;
    do begin step(); k++; end while (tx_en !== 1'b0 && k < 20);
    check("t4_launch_seen", 64'(tx_en), 64'd0);
    k = 0;
    while (!timeout_err && k < int'(TO_CYC) + 50) begin step(); k++; end
    check("t4_to_cycles", 64'(k), 64'(TO_CYC));
    check("t4_err_set",   64'(timeout_err), 64'd1);
    check("t4_busy_off",  64'(busy), 64'd0);
    stall = 1'b0;
    step();
    check("t4_next_ack", 64'(ack), 64'h8);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4_err_clr", 64'(timeout_err), 64'd0);
    wait_idle("t4");

    // reset in WAIT_LO with 0 and 3 pending; rr_ptr restarts at 0
    new_payloads();
    push(1);
    wait_done(1'b1, "t5_done_rise");
    repeat (5) step();
    check("t5_mid_busy", 64'(busy), 64'd1);
    push(0); push(3);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_tx_en",   64'(tx_en), 64'd1);
    check("t5_rst_busy",    64'(busy), 64'd0);
    check("t5_rst_ack",     64'(ack), 64'd0);
    check("t5_rst_tx_byte", tx_byte, 64'd0);
    wait_done(1'b0, "t5_tx_finish");
    step();
    reset_n = 1'b1;
    wait_idle("t5");

    // all four held, source 0 repeats: 0,1,2,3,0
    new_payloads();
    push(0); push(1); push(2); push(3); push(0);
    wait_idle("t2");

    repeat (50) step();
    check("end_ack_q", 64'(ack_q.size()), 64'd0);
    check("end_frm_q", 64'(frm_q.size()), 64'd0);
    check("end_dec_q", 64'(dec_q.size()), 64'd0);
    check("end_err",   64'(timeout_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
